conv_frame_encoder: RTL and testbench
=====================================

# conv_frame_encoder

Rate-1/2, constraint-length-3 convolutional encoder with byte-wide input handshake and bit-serial output. Sits directly upstream of the serial read-out/reversal stage. It turns frames of `FRAME_BYTES` bytes into a coded bit stream on `out_pre_sequence`, qualified by `code_en`. The downstream stage advances only on `code_en`, so gaps are permitted.

## Interface
- `FRAME_BYTES`, default 4: bytes per frame, range 1..255.
- `G0`, default 3'b111: generator for the first coded bit. Taps are {b, s1, s0}.
- `G1`, default 3'b101: generator for the second coded bit.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `din` in 8: information byte, sent MSB first.
- `din_valid` in 1: `din` holds a byte.
- `din_ready` out 1: block will take the byte at the next edge. Combinational from state.
- `out_pre_sequence` out 1: coded bit, registered.
- `code_en` out 1: `out_pre_sequence` is valid this cycle, registered.
- `frame_done` out 1: one-cycle pulse after the last coded bit of a frame, registered.

## Operation
- States: IDLE, ENC, WAIT, TAIL.
- Encoder memory is {s1, s0}, with s1 the most recent bit.
  - c0 = ^(G0 & {b,s1,s0}); c1 = ^(G1 & {b,s1,s0}).
  - After c1 is emitted: s0<=s1, s1<=b.
- IDLE:
  - `din_ready`=1, `code_en`=0.
  - Handshake (`din_valid`&&`din_ready` at an edge) loads the byte, clears {s1,s0}, clears the byte counter, registers c0 of bit 7, and moves to ENC.
- ENC:
  - Emits c0 then c1 for each bit, MSB first: 16 consecutive `code_en` cycles per byte.
  - `din_ready`=1 only in the c1-of-bit-0 cycle, and only when byte_cnt < FRAME_BYTES-1.
  - Handshake in that cycle loads the next byte with no gap. Encoder memory carries over; it is not cleared mid-frame.
  - No `din_valid` in that cycle with bytes remaining: go to WAIT.
  - Last byte of the frame finished: go to TAIL, or to IDLE if tail is disabled.
- WAIT:
  - `code_en`=0, `din_ready`=1, encoder memory held.
  - Handshake resumes ENC exactly as a back-to-back load.
  - WAIT never times out.
- TAIL: encodes two zero bits, giving 4 coded cycles, then goes to IDLE.
- `frame_done` asserts on the transition into IDLE.
- `din_ready` is also high in the `frame_done` cycle, because the block is already in IDLE.
- `din_valid` with `din_ready`=0 is ignored; the byte is not consumed.

## Timing
- Reset:
  - Applies at the first edge with `rst_n`=0.
  - Outputs after that edge: `out_pre_sequence`=0, `code_en`=0, `frame_done`=0.
  - State IDLE, memory 00, counters 0, `din_ready`=1 once `rst_n`=1.
- Latency: handshake at edge E puts c0 of MSB on the output in the cycle after E. c1 of bit 0 appears after edge E+15.
- Frame length in `code_en` cycles: 16·FRAME_BYTES, plus 4 with tail. There are no gaps if `din_valid` is held high.
- `frame_done` is high in the cycle immediately after the last `code_en` cycle, for exactly 1 cycle.
- Reset mid-frame: the partial frame is discarded, there is no `frame_done`, and the next handshake starts a new frame.
- byte_cnt is 8 bits and saturates logic at FRAME_BYTES-1; it never wraps.

## Configuration
- `CONV_TAIL_EN` defined: TAIL state present. Each frame ends with 2 zero bits, so the encoder returns to state 00. Frame is 16·FRAME_BYTES+4 coded bits.
- Undefined: no TAIL state. `frame_done` follows the last data c1. Frame is 16·FRAME_BYTES coded bits.

## Structure
- Package `conv_pkg`: K=3, state enum (IDLE/ENC/WAIT/TAIL), default G0/G1 constants, byte width 8.
- Sub-module `conv_k3_core`: memory register plus parity for c0/c1. Controls are step, clear and bit input. The top level holds the FSM, byte shift register, counters and output registers.

## Test plan
- Reset, then FRAME_BYTES=1, `din`=0x80 → coded pairs 11 10 11 00 00 00 00 00. With tail, add 00 00. `frame_done` in the cycle after the last coded bit.
- FRAME_BYTES=1, `din`=0xFF → 11 01 10 10 10 10 10 10. With `CONV_TAIL_EN`, tail 01 11. Total 20 `code_en` cycles.
- FRAME_BYTES=2, `din_valid` held with 0x80 then 0x00 → 32 contiguous `code_en` cycles. Memory carries into the second byte: pairs are 11 10 11 00… then all 00.
- FRAME_BYTES=2, `din_valid` dropped for 5 cycles at the byte boundary → exactly 5 `code_en`=0 cycles. Resumed output is identical to the contiguous case.
- `rst_n` low for 1 cycle during bit 3 of a byte → next cycle all outputs 0, no `frame_done`. A new 0x80 frame reproduces the first scenario exactly.
- `din_valid` high during ENC when `din_ready`=0 → byte not consumed. The same byte is accepted at the next ready cycle.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants, FSM state type and parity helper for the K=3 convolutional encoder.
package conv_pkg;

  localparam int unsigned K      = 3;
  localparam int unsigned BYTE_W = 8;

  localparam logic [K-1:0] G0_DEFAULT = 3'b111;
  localparam logic [K-1:0] G1_DEFAULT = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ENC,
    WAIT,
    TAIL
  } conv_state_e;

  // Parity of the generator-selected taps {b, s1, s0}.
  function automatic logic conv_parity(input logic [K-1:0] g, input logic [K-1:0] taps);
    return ^(g & taps);
  endfunction

endpackage

// File: rtl/conv_frame_encoder_if.sv
// Byte-in / coded-bit-out bus of the convolutional frame encoder.
interface conv_frame_encoder_if;
  import conv_pkg::*;

  logic [BYTE_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              out_pre_sequence;
  logic              code_en;
  logic              frame_done;

  // Byte source and coded-bit sink.
  modport master (
    output din, din_valid,
    input  din_ready, out_pre_sequence, code_en, frame_done
  );

  // Encoder side.
  modport slave (
    input  din, din_valid,
    output din_ready, out_pre_sequence, code_en, frame_done
  );

endinterface

// File: rtl/conv_k3_core.sv
// K=3 encoder memory {s1, s0} and the two generator parities for the bit on bit_i.
module conv_k3_core
  import conv_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEFAULT,
  parameter logic [K-1:0] G1 = G1_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic step_i,
  input  logic bit_i,
  output logic c0_o,
  output logic c1_o
);

  logic         s1_q;
  logic         s0_q;
  logic [K-1:0] taps;

  // Parities see a zeroed memory while a clear is requested so a frame's first bit codes from state 00.
  always_comb begin
    taps = clear_i ? {bit_i, 2'b00} : {bit_i, s1_q, s0_q};
    c0_o = conv_parity(G0, taps);
    c1_o = conv_parity(G1, taps);
  end

  // Memory shift: s1 takes the newest bit, s0 the previous s1.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      s1_q <= 1'b0;
      s0_q <= 1'b0;
    end else if (step_i) begin
      s1_q <= bit_i;
      s0_q <= s1_q;
    end
  end

endmodule

// File: rtl/conv_frame_encoder.sv
// Rate-1/2, K=3 convolutional frame encoder: byte handshake in, bit-serial coded stream out.
// Optional feature macro: CONV_TAIL_EN (appends two zero bits per frame to flush the memory to 00).
module conv_frame_encoder
  import conv_pkg::*;
#(
  parameter int unsigned  FRAME_BYTES = 4,
  parameter logic [K-1:0] G0          = G0_DEFAULT,
  parameter logic [K-1:0] G1          = G1_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  conv_frame_encoder_if.slave  bus
);

  localparam logic [7:0] LAST_BYTE = 8'(FRAME_BYTES - 1);

  conv_state_e       state_q;
  logic [BYTE_W-1:0] byte_q;
  logic [2:0]        bit_cnt_q;
  logic              phase_q;     // 0: c0 on the output, 1: c1 on the output
  logic [7:0]        byte_cnt_q;
  logic              out_q;
  logic              code_en_q;
  logic              frame_done_q;

  logic din_ready;
  logic hs;
  logic more_bytes;
  logic enc_bit;
  logic core_clear;
  logic core_step;
  logic c0;
  logic c1;

  // The memory steps at the c0->c1 edge rather than after c1, so the parity on enc_bit always
  // yields the next registered coded bit: current bit during c0, following bit during c1.
  always_comb begin
    more_bytes = (byte_cnt_q < LAST_BYTE);
    din_ready  = 1'b0;
    enc_bit    = 1'b0;
    case (state_q)
      IDLE, WAIT: begin
        din_ready = 1'b1;
        enc_bit   = bus.din[7];
      end
      ENC: begin
        if (!phase_q) begin
          enc_bit = byte_q[7];
        end else if (bit_cnt_q != 3'd0) begin
          enc_bit = byte_q[6];
        end else if (more_bytes) begin
          din_ready = 1'b1;
          enc_bit   = bus.din[7];
        end
      end
      default: ;
    endcase
    hs         = bus.din_valid && din_ready;
    core_clear = (state_q == IDLE) && hs;
    core_step  = ((state_q == ENC) || (state_q == TAIL)) && !phase_q;
  end

  conv_k3_core #(
    .G0 (G0),
    .G1 (G1)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (core_clear),
    .step_i  (core_step),
    .bit_i   (enc_bit),
    .c0_o    (c0),
    .c1_o    (c1)
  );

  // Frame FSM with registered coded bit, qualifier and frame-done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      byte_q       <= '0;
      bit_cnt_q    <= '0;
      phase_q      <= 1'b0;
      byte_cnt_q   <= '0;
      out_q        <= 1'b0;
      code_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hs) begin
            byte_q     <= bus.din;
            bit_cnt_q  <= 3'd7;
            phase_q    <= 1'b0;
            byte_cnt_q <= '0;
            out_q      <= c0;
            code_en_q  <= 1'b1;
            state_q    <= ENC;
          end else begin
            out_q     <= 1'b0;
            code_en_q <= 1'b0;
          end
        end
        WAIT: begin
          if (hs) begin
            byte_q     <= bus.din;
            bit_cnt_q  <= 3'd7;
            phase_q    <= 1'b0;
            byte_cnt_q <= more_bytes ? byte_cnt_q + 8'd1 : byte_cnt_q;
            out_q      <= c0;
            code_en_q  <= 1'b1;
            state_q    <= ENC;
          end
        end
        ENC: begin
          if (!phase_q) begin
            out_q   <= c1;
            phase_q <= 1'b1;
          end else if (bit_cnt_q != 3'd0) begin
            byte_q    <= {byte_q[BYTE_W-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q - 3'd1;
            out_q     <= c0;
            phase_q   <= 1'b0;
          end else if (more_bytes) begin
            if (hs) begin
              byte_q     <= bus.din;
              bit_cnt_q  <= 3'd7;
              phase_q    <= 1'b0;
              byte_cnt_q <= byte_cnt_q + 8'd1;
              out_q      <= c0;
            end else begin
              out_q     <= 1'b0;
              code_en_q <= 1'b0;
              state_q   <= WAIT;
            end
          end else begin
`ifdef CONV_TAIL_EN
            bit_cnt_q <= 3'd1;
            phase_q   <= 1'b0;
            out_q     <= c0;
            state_q   <= TAIL;
`else
            out_q        <= 1'b0;
            code_en_q    <= 1'b0;
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
`endif
          end
        end
        TAIL: begin
          if (!phase_q) begin
            out_q   <= c1;
            phase_q <= 1'b1;
          end else if (bit_cnt_q != 3'd0) begin
            bit_cnt_q <= 3'd0;
            out_q     <= c0;
            phase_q   <= 1'b0;
          end else begin
            out_q        <= 1'b0;
            code_en_q    <= 1'b0;
            frame_done_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.din_ready        = din_ready;
  assign bus.out_pre_sequence = out_q;
  assign bus.code_en          = code_en_q;
  assign bus.frame_done       = frame_done_q;

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Scoreboard bench for conv_frame_encoder: dut0 with FRAME_BYTES=1, dut1 with FRAME_BYTES=2.
module tb_conv_frame_encoder;

`ifdef CONV_TAIL_EN
  localparam int TAIL_LEN = 4;
`else
  localparam int TAIL_LEN = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  conv_frame_encoder_if if0 ();
  conv_frame_encoder_if if1 ();

  conv_frame_encoder #(.FRAME_BYTES(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  conv_frame_encoder #(.FRAME_BYTES(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int checks   = 0;
  int failures = 0;

  int   q0[$];
  int   q1[$];
  int   active[2];
  int   flen[2];
  int   fgap[2];
  int   last_gap[2];
  int   last_wait;
  logic ms1[2];
  logic ms0[2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void sb_push(input int d, input int v);
    if (d == 0) q0.push_back(v); else q1.push_back(v);
  endfunction

  function automatic int sb_size(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int sb_front(input int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void sb_pop(input int d);
    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction

  // Golden coded bits, MSB first.
  function automatic void push_vec(input int d, input logic [15:0] v);
    for (int i = 15; i >= 0; i--) sb_push(d, int'(v[i]));
  endfunction

  function automatic void push_tail(input int d, input logic [3:0] t);
`ifdef CONV_TAIL_EN
    for (int i = 3; i >= 0; i--) sb_push(d, int'(t[i]));
`else
    if (t == 4'hF) sb_push(d, 0); // never true for the tails used; keeps t referenced
    if (t == 4'hF) sb_pop(d);
`endif
  endfunction

  // Independent reference encoder with G0=111, G1=101.
  function automatic void model_bit(input int d, input logic b);
    logic [2:0] t;
    t = {b, ms1[d], ms0[d]};
    sb_push(d, int'(^(3'b111 & t)));
    sb_push(d, int'(^(3'b101 & t)));
    ms0[d] = ms1[d];
    ms1[d] = b;
  endfunction

  function automatic void model_byte(input int d, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) model_bit(d, b[i]);
  endfunction

  function automatic void model_end(input int d);
`ifdef CONV_TAIL_EN
    model_bit(d, 1'b0);
    model_bit(d, 1'b0);
`endif
    sb_push(d, 2);
  endfunction

  function automatic logic rdy(input int d);
    return (d == 0) ? if0.din_ready : if1.din_ready;
  endfunction

  task automatic drive(input int d, input logic [7:0] b, input logic v);
    if (d == 0) begin
      if0.din = b; if0.din_valid = v;
    end else begin
      if1.din = b; if1.din_valid = v;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge with valid still high.
  task automatic put_byte(input int d, input logic [7:0] b);
    int waited;
    waited = 0;
    drive(d, b, 1'b1);
    while (!rdy(d) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    last_wait = waited;
    if (!rdy(d)) begin
      check_val("ready_timeout", 32'(rdy(d)), 1);
      return;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (sb_size(d) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check_val("drain", sb_size(d), 0);
  endtask

  // Output monitor: pops one expected bit per code_en cycle; marker 2 expects frame_done.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic ce, od, fd;
      ce = (d == 0) ? if0.code_en          : if1.code_en;
      od = (d == 0) ? if0.out_pre_sequence : if1.out_pre_sequence;
      fd = (d == 0) ? if0.frame_done       : if1.frame_done;
      if (ce) begin
        active[d] = 1;
        flen[d]++;
        if (sb_size(d) == 0 || sb_front(d) == 2) begin
          check_val("code_en_unexpected", 32'(ce), 0);
        end else begin
          check_val("coded_bit", 32'(od), sb_front(d));
          sb_pop(d);
        end
      end else if (sb_size(d) != 0 && sb_front(d) == 2 && active[d] != 0) begin
        check_val("frame_done", 32'(fd), 1);
        check_val("frame_len", flen[d], (d == 0) ? 16 + TAIL_LEN : 32 + TAIL_LEN);
        sb_pop(d);
        last_gap[d] = fgap[d];
        active[d]   = 0;
        flen[d]     = 0;
        fgap[d]     = 0;
      end else if (fd) begin
        check_val("frame_done_spurious", 32'(fd), 0);
      end else if (active[d] != 0) begin
        fgap[d]++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r0, r1;
    for (int d = 0; d < 2; d++) begin
      active[d] = 0; flen[d] = 0; fgap[d] = 0; last_gap[d] = -1;
      ms1[d] = 1'b0; ms0[d] = 1'b0;
    end
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check_val("rst_out0",   32'(if0.out_pre_sequence), 0);
    check_val("rst_ce0",    32'(if0.code_en), 0);
    check_val("rst_fd0",    32'(if0.frame_done), 0);
    check_val("rst_ready0", 32'(if0.din_ready), 1);
    check_val("rst_ready1", 32'(if1.din_ready), 1);

    // FRAME_BYTES=1, 0x80
    push_vec(0, 16'hEC00); push_tail(0, 4'b0000); sb_push(0, 2);
    put_byte(0, 8'h80);
    drive(0, 8'h00, 1'b0);
    drain(0);

    // FRAME_BYTES=1, 0xFF
    push_vec(0, 16'hDAAA); push_tail(0, 4'b0111); sb_push(0, 2);
    put_byte(0, 8'hFF);
    drive(0, 8'h00, 1'b0);
    drain(0);

    // FRAME_BYTES=2, contiguous 0x80 0x00; second byte held while not ready
    push_vec(1, 16'hEC00); push_vec(1, 16'h0000); push_tail(1, 4'b0000); sb_push(1, 2);
    put_byte(1, 8'h80);
    put_byte(1, 8'h00);
    check_val("ready_wait", last_wait, 15);
    drive(1, 8'h00, 1'b0);
    drain(1);
    check_val("gap_contig", last_gap[1], 0);

    // FRAME_BYTES=2, valid dropped for 5 cycles at the byte boundary
    push_vec(1, 16'hEC00); push_vec(1, 16'h0000); push_tail(1, 4'b0000); sb_push(1, 2);
    put_byte(1, 8'h80);
    drive(1, 8'h00, 1'b0);
    repeat (20) @(negedge clk);
    put_byte(1, 8'h00);
    drive(1, 8'h00, 1'b0);
    drain(1);
    check_val("gap_5", last_gap[1], 5);

    // Reset mid-frame during bit 3
    push_vec(0, 16'hEC00); push_tail(0, 4'b0000); sb_push(0, 2);
    put_byte(0, 8'h80);
    drive(0, 8'h00, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      active[d] = 0; flen[d] = 0; fgap[d] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_val("mid_rst_out",   32'(if0.out_pre_sequence), 0);
    check_val("mid_rst_ce",    32'(if0.code_en), 0);
    check_val("mid_rst_fd",    32'(if0.frame_done), 0);
    check_val("mid_rst_ready", 32'(if0.din_ready), 1);
    repeat (4) @(negedge clk);

    // Fresh 0x80 frame after the reset
    push_vec(0, 16'hEC00); push_tail(0, 4'b0000); sb_push(0, 2);
    put_byte(0, 8'h80);
    drive(0, 8'h00, 1'b0);
    drain(0);

    // Random two-byte frame against the reference model
    r0 = 8'($urandom);
    r1 = 8'($urandom);
    ms1[1] = 1'b0; ms0[1] = 1'b0;
    model_byte(1, r0); model_byte(1, r1); model_end(1);
    put_byte(1, r0);
    put_byte(1, r1);
    drive(1, 8'h00, 1'b0);
    drain(1);
    check_val("gap_rand", last_gap[1], 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
